// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request, ALU mux, multi-cycle unit and response signals of the op sequencer
// Ports (by modport):
//   master - requester/datapath side: drives req_valid, req_op, alu_out, mc_done, rsp_ready
//   slave  - sequencer side: drives req_ready, alu_sel, mc_start, rsp_valid, rsp_data, rsp_err, busy
interface alu_op_sequencer_if #(
    parameter int N = 32
);
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [2:0]   alu_sel;
    logic [N-1:0] alu_out;
    logic         mc_start;
    logic         mc_done;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;
    logic         rsp_err;
    logic         busy;
    modport master (
        output req_valid, req_op, alu_out, mc_done, rsp_ready,
        input  req_ready, alu_sel, mc_start, rsp_valid, rsp_data, rsp_err, busy
    );
    modport slave (
        input  req_valid, req_op, alu_out, mc_done, rsp_ready,
        output req_ready, alu_sel, mc_start, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one ALU op at a time, waits on multi-cycle units, returns the result
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - alu_op_sequencer_if.slave: request (req_*), ALU mux select/result (alu_sel/alu_out),
//           multi-cycle unit start/done (mc_start/mc_done), response (rsp_*), busy
module alu_op_sequencer #(
    parameter int N       = 32,
    parameter int TIMEOUT = 64
) (
    input logic               clk,
    input logic               rst_n,
    alu_op_sequencer_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, SINGLE, MC_WAIT, RESP} state_t;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_sel;
    logic          r_mc_start;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic [N-1:0]  r_rsp_data;
    logic          w_done;
    logic          w_tmo;
    logic          w_mc_op;
    // r_mc_start is high exactly in the first MC_WAIT cycle, where mc_done is ignored
    assign w_done        = !r_mc_start && bus.mc_done;
    assign w_tmo         = r_cnt == CW'(TIMEOUT - 1);
    assign w_mc_op       = bus.req_op == 3'd4 || bus.req_op == 3'd5;
    assign bus.req_ready = r_state == IDLE;
    assign bus.busy      = r_state != IDLE;
    assign bus.alu_sel   = r_sel;
    assign bus.mc_start  = r_mc_start;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_sel       <= '0;
            r_mc_start  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    r_sel <= bus.req_op;
                    if (w_mc_op) begin
                        r_state    <= MC_WAIT;
                        r_mc_start <= 1'b1;
                        r_cnt      <= '0;
                    end else if (bus.req_op == 3'd6) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                    end else begin
                        r_state <= SINGLE;
                    end
                end
                SINGLE: begin
                    r_state     <= RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= bus.alu_out;
                    r_rsp_err   <= 1'b0;
                end
                MC_WAIT: begin
                    r_mc_start <= 1'b0;
                    r_cnt      <= r_cnt + 1'b1;
                    // completion takes priority over a timeout in the same cycle
                    if (w_done || w_tmo) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_done ? bus.alu_out : '0;
                        r_rsp_err   <= !w_done;
                    end
                end
                RESP: if (bus.rsp_ready) begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue side of the ALU result-select path: accepts one operation request at a time and drives the 3-bit select to the ALU result mux.
- Starts multi-cycle units (codes 4 and 5) and waits for their completion.
- Captures the mux output and returns it to the requester through a valid/ready response channel.
- Flags unused select code 6 and unit timeouts as errors.

Parameters:
- N, 32, data width of the ALU result and response data.
- TIMEOUT, 64, max cycles MC_WAIT waits for mc_done before an error response (>=2).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_op  input  3  operation code; equals the mux select code.
- alu_sel  output  3  select to the ALU result mux; registered.
- alu_out  input  N  selected result returned by the mux.
- mc_start  output  1  one-cycle start pulse to the multi-cycle units (ops 4, 5).
- mc_done  input  1  multi-cycle unit result valid on alu_out this cycle.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_data  output  N  captured result; 0 on error.
- rsp_err  output  1  response is an error (op 6 or timeout).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; alu_sel=0, mc_start=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, timeout counter=0. An in-flight op is discarded with no response, and any mc_start pulse is dropped.
- States: IDLE, SINGLE, MC_WAIT, RESP.
- req_ready = (state==IDLE), combinational from state. A request is accepted when req_valid && req_ready; req_op is sampled only then.
- IDLE, on accept:
  - alu_sel <= req_op.
  - op in {0,1,2,3,7}: go to SINGLE.
  - op in {4,5}: go to MC_WAIT, with mc_start <= 1 and counter <= 0.
  - op 6: go to RESP with rsp_data <= 0 and rsp_err <= 1; alu_out is not sampled.
- SINGLE: lasts exactly one cycle. rsp_data <= alu_out, rsp_err <= 0, then go to RESP.
  - Latency: accept edge T; alu_sel valid during cycle T+1; rsp_valid high from cycle T+2.
- MC_WAIT:
  - mc_start is high only during the first MC_WAIT cycle; mc_done is ignored in that cycle.
  - From the second cycle on, mc_done=1 gives rsp_data <= alu_out, rsp_err <= 0, then go to RESP.
  - The counter increments every MC_WAIT cycle. If counter==TIMEOUT-1 and mc_done=0: rsp_data <= 0, rsp_err <= 1, then go to RESP.
  - mc_done and the timeout in the same cycle: mc_done wins, normal response.
- RESP: rsp_valid=1. rsp_data and rsp_err are held stable until rsp_valid && rsp_ready, then go to IDLE. No request is accepted in RESP; there is no overlap of ops.
  - Best-case throughput is one single-cycle op per 3 cycles.
- alu_sel holds the last issued op after completion; it changes only on accept or reset.
- mc_done outside MC_WAIT is ignored.
- rsp_valid, rsp_data, rsp_err and mc_start are registered outputs. busy = (state!=IDLE).
- No arithmetic other than the counter. Counter width is clog2(TIMEOUT); it saturates only via the state exit.

Test Plan:
- Reset mid-MC_WAIT: issue op 4, assert rst_n=0 two cycles later -> all outputs 0 immediately (async); after release req_ready=1 and no rsp_valid appears.
- Single-cycle op with rsp_ready=1:
  - Stimulus: op 3 accepted at edge T; mux returns alu_out=32'hDEAD_BEEF when alu_sel==3.
  - Response: alu_sel==3 at T+1; rsp_valid=1 at T+2 with rsp_data=32'hDEAD_BEEF, rsp_err=0; req_ready=1 at T+3.
- Backpressure:
  - Stimulus: op 7 with alu_out=32'h0000_0001; rsp_ready=0 for 5 cycles, then 1.
  - Response: rsp_valid and rsp_data are held stable all 5 cycles; req_valid ignored meanwhile; IDLE the cycle after the handshake.
- Multi-cycle op 5:
  - Stimulus: mc_done=1 with alu_out=32'h1234 on the 4th MC_WAIT cycle.
  - Response: exactly one mc_start pulse in the first MC_WAIT cycle; rsp_data=32'h1234, rsp_err=0. mc_done=1 during the start cycle alone does not complete the op.
- Invalid op 6 -> no mc_start; rsp_valid 1 cycle after accept with rsp_data=0, rsp_err=1; alu_sel==6.
- Timeout with TIMEOUT=8:
  - op 4 with mc_done never asserted -> rsp_err=1, rsp_data=0 after exactly 8 MC_WAIT cycles.
  - Repeat with mc_done=1 on the 8th cycle -> normal response, rsp_err=0.
